// File: rtl/regfile_wb_scheduler_pkg.sv
// regfile_wb_scheduler_pkg: shared encodings and defaults for the register-file writeback scheduler.
package regfile_wb_scheduler_pkg;
    localparam int AW_DEF = 5;
    localparam int DW_DEF = 32;
    localparam logic [AW_DEF-1:0] R0 = '0;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_FORCE = 2'd2;
endpackage

// File: rtl/regfile_wb_scheduler_scoreboard.sv
// regfile_scoreboard: per-register busy bits for outstanding long-latency destinations.
// Set wins over clear on the same register; r0 is never busy.
module regfile_scoreboard
    import regfile_wb_scheduler_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_set_en,
    input  logic [AW-1:0] i_set_num,
    input  logic          i_clr_en,
    input  logic [AW-1:0] i_clr_num,
    input  logic [AW-1:0] i_rs_num,
    input  logic [AW-1:0] i_rt_num,
    input  logic [AW-1:0] i_dst_num,
    input  logic          i_use_rs,
    input  logic          i_use_rt,
    input  logic          i_use_dst,
    output logic          o_stall
);
    localparam int N = 1 << AW;
    logic [N-1:0] r_busy;
    logic [N-1:0] w_set;
    logic [N-1:0] w_clr;
    assign w_set = i_set_en ? (N'(1) << i_set_num) & ~N'(1) : '0;
    assign w_clr = i_clr_en ? (N'(1) << i_clr_num) : '0;
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            r_busy <= '0;
        else
            r_busy <= (r_busy & ~w_clr) | w_set;
    end
    assign o_stall = (i_use_rs && r_busy[i_rs_num]) ||
                     (i_use_rt && r_busy[i_rt_num]) ||
                     (i_use_dst && r_busy[i_dst_num]);
endmodule

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: arbitrates the single register-file write port between WB and mul/div,
// with a starvation FSM that freezes the pipeline for one forced mul/div grant.
module regfile_wb_scheduler
    import regfile_wb_scheduler_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_WAIT = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_num,
    input  logic [DW-1:0] wb_data,
    input  logic          md_valid,
    input  logic [AW-1:0] md_num,
    input  logic [DW-1:0] md_data,
    output logic          md_ready,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_num,
    input  logic [AW-1:0] rs_num,
    input  logic [AW-1:0] rt_num,
    input  logic [AW-1:0] dst_num,
    input  logic          use_rs,
    input  logic          use_rt,
    input  logic          use_dst,
    output logic          raw_stall,
    output logic          pipe_hold,
    output logic          rf_we,
    output logic [AW-1:0] rf_wnum,
    output logic [DW-1:0] rf_wdata
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    logic [1:0]    r_state;
    logic [CW-1:0] r_wait_cnt;
    logic          w_wb_req;
    logic          w_md_grant;
    logic          w_blocked;
    logic          w_xfer;
    logic          w_stall;
    assign w_wb_req   = wb_en && wb_num != AW'(R0);
    assign w_md_grant = r_state == S_FORCE || (!w_wb_req && md_valid);
    assign w_blocked  = md_valid && !w_md_grant;
    assign w_xfer     = md_valid && w_md_grant;
    assign md_ready   = w_md_grant && !reset;
    assign pipe_hold  = r_state == S_FORCE && !reset;
    assign rf_we      = !reset && (w_md_grant ? md_num != AW'(R0) : w_wb_req);
    assign rf_wnum    = w_md_grant ? md_num : wb_num;
    assign rf_wdata   = w_md_grant ? md_data : wb_data;
    assign raw_stall  = w_stall && !reset;
    // IDLE counts as the first blocked cycle, so FORCE follows MAX_WAIT blocked cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
        end else if (r_state == S_FORCE || !w_blocked) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
        end else if (r_state == S_IDLE ? MAX_WAIT == 1 : r_wait_cnt == CW'(MAX_WAIT - 1)) begin
            r_state    <= S_FORCE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= S_WAIT;
            r_wait_cnt <= r_wait_cnt + CW'(1);
        end
    end
    regfile_scoreboard #(.AW(AW)) u_sb (
        .i_clock   (clock),
        .i_reset   (reset),
        .i_set_en  (iss_valid),
        .i_set_num (iss_num),
        .i_clr_en  (w_xfer),
        .i_clr_num (md_num),
        .i_rs_num  (rs_num),
        .i_rt_num  (rt_num),
        .i_dst_num (dst_num),
        .i_use_rs  (use_rs),
        .i_use_rt  (use_rt),
        .i_use_dst (use_dst),
        .o_stall   (w_stall)
    );
endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Shares the register file's single write port between the pipeline writeback stage and the long-latency mul/div unit.
- Keeps a per-register busy scoreboard for outstanding mul/div destinations and raises a RAW/WAW stall to the decode stage.
- Guarantees mul/div forward progress with a starvation counter that freezes the pipeline for one cycle.
- Sits between the WB stage, the mul/div unit and the register file write port (register file writes on negedge clock).

Parameters:
- AW, 5, register-number width (32 registers, r0 hard-wired zero)
- DW, 32, data width
- MAX_WAIT, 4, blocked mul/div cycles before a forced grant (>=1)

Ports:
- clock  in  1  system clock; all state updates on posedge
- reset  in  1  reset, asynchronous, active-high
- wb_en  in  1  pipeline writeback request
- wb_num  in  AW  pipeline destination register
- wb_data  in  DW  pipeline writeback data
- md_valid  in  1  mul/div result valid
- md_num  in  AW  mul/div destination register
- md_data  in  DW  mul/div result data
- md_ready  out  1  mul/div result accepted this cycle
- iss_valid  in  1  long-latency op issued this cycle
- iss_num  in  AW  destination of the issued op
- rs_num, rt_num, dst_num  in  AW each  decode-stage source and destination numbers
- use_rs, use_rt, use_dst  in  1 each  qualifiers for rs_num, rt_num, dst_num
- raw_stall  out  1  decode must stall
- pipe_hold  out  1  freeze the whole pipeline this cycle (forced mul/div grant)
- rf_we  out  1  register file write enable
- rf_wnum  out  AW  register file write number
- rf_wdata  out  DW  register file write data

Behaviour:
- Reset (async, any time, including mid-wait): busy all 0, state IDLE, wait_cnt 0. While reset=1, rf_we, md_ready, pipe_hold and raw_stall are all 0.
- Pipeline request: wb_req = wb_en && wb_num!=0. A pipeline write to r0 is not a request.
- Grant rules, combinational, same cycle:
  - state FORCE: grant mul/div.
  - otherwise, if wb_req: grant pipeline.
  - otherwise, if md_valid: grant mul/div.
- md_ready = (mul/div granted). Transfer = md_valid && md_ready.
- Write-port outputs are muxed from the granted source. rf_we = granted && num!=0, so a mul/div result to r0 is accepted but never written. Zero latency: data reaches the register file on the negedge of the same cycle.
- Handshake: md_valid/md_num/md_data must stay stable until transfer. Dropping md_valid early is illegal; the FSM returns to IDLE.
- FSM with states IDLE, WAIT, FORCE. A blocked cycle is md_valid && !md_ready.
  - IDLE: a blocked cycle -> WAIT with wait_cnt=1.
  - WAIT: transfer -> IDLE with wait_cnt=0. A blocked cycle with wait_cnt==MAX_WAIT-1 -> FORCE. Otherwise a blocked cycle increments wait_cnt.
  - FORCE: pipe_hold=1 for exactly one cycle and mul/div is granted. The pipeline write presented that cycle is NOT performed; the frozen pipeline re-presents it next cycle. Next state is IDLE, wait_cnt=0.
- Scoreboard, busy[1..31], updated on posedge:
  - set on iss_valid && iss_num!=0;
  - cleared on transfer to md_num;
  - same register set and cleared in one cycle -> set wins.
  - busy[0] is constant 0.
- raw_stall = (use_rs&&busy[rs_num]) || (use_rt&&busy[rt_num]) || (use_dst&&busy[dst_num]), combinational.
- A register being cleared this cycle still stalls; it is released the next cycle. This is conservative: no bypass.
- Issuing to a busy register is prevented by the use_dst stall. The block does not check it further.

Decomposition:
- Shared CPU package holds:
  - FSM state encodings (IDLE/WAIT/FORCE);
  - the r0 constant;
  - AW/DW defaults.
- One sub-module, regfile_scoreboard:
  - busy vector with set/clear;
  - three read ports and stall OR.
- Arbiter, FSM and write mux stay in the top module.

Test Plan:
- Pipeline only: wb_en=1, wb_num=5, wb_data=0xDEADBEEF, md_valid=0 -> rf_we=1, rf_wnum=5 same cycle; r5 reads 0xDEADBEEF after negedge.
- Idle port: md_valid=1, md_num=8, md_data=0x12, wb_en=0 -> md_ready=1 same cycle, rf_we=1. busy[8], set earlier by iss, clears and raw_stall(rs=8) drops the next cycle.
- Starvation, MAX_WAIT=4: wb_en=1 (r3) held with md_valid=1 (r9) -> md_ready=0 for 4 cycles, then pipe_hold=1 and md_ready=1 with rf_wnum=9 in cycle 5. The r3 write is deferred and occurs in cycle 6.
- Scoreboard set/clear collision: iss_valid=1, iss_num=7 in the same cycle as a transfer to r7 -> busy[7]=1 afterwards; use_rt=1, rt_num=7 gives raw_stall=1.
- r0 cases: iss_num=0 leaves busy unchanged; a mul/div result to r0 gives md_ready=1, rf_we=0; wb_en=1, wb_num=0 does not block a pending mul/div.
- Async reset in WAIT with busy[4]=1 -> immediately state IDLE, busy cleared, md_ready/rf_we/pipe_hold/raw_stall 0, with no clock edge required.
